// File: rtl/seg_instruction_fetch_pkg.sv
// Shared fetch-stage constants; also used by decode and the debug unit.
package seg_instruction_fetch_pkg;

    localparam int LEN = 32;

    localparam logic [LEN-1:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [LEN-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [LEN-1:0] PC_RESET  = 32'h0000_0000;
    localparam logic [LEN-1:0] PC_INCR   = 32'h0000_0004;

endpackage

// File: rtl/seg_instruction_fetch_mem_instruction.sv
// Instruction RAM: combinational read, synchronous write (debug-unit loaded).
module mem_instruction #(
    parameter int LEN         = 32,
    parameter int NB_MEM_ADDR = 10
) (
    input  logic                   i_clk,
    input  logic                   i_wr_en,
    input  logic [NB_MEM_ADDR-1:0] i_wr_addr,
    input  logic [LEN-1:0]         i_wr_data,
    input  logic [NB_MEM_ADDR-1:0] i_rd_addr,
    output logic [LEN-1:0]         o_rd_data
);

    logic [LEN-1:0] mem_q [2**NB_MEM_ADDR];

    // Contents are deliberately not reset so a loaded program survives a core reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/seg_instruction_fetch.sv
// IF stage: PC register, next-PC select, instruction RAM and IF/ID register.
module seg_instruction_fetch #(
    parameter int             LEN         = seg_instruction_fetch_pkg::LEN,
    parameter int             NB_MEM_ADDR = 10,
    parameter logic [LEN-1:0] HALT_WORD   = LEN'(seg_instruction_fetch_pkg::HALT_WORD)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_jump_flag,
    input  logic [LEN-1:0]         i_PC_dir_jump,
    input  logic                   i_branch_flag,
    input  logic [LEN-1:0]         i_PC_branch,
    input  logic                   i_prog_wr_en,
    input  logic [NB_MEM_ADDR-1:0] i_prog_wr_addr,
    input  logic [LEN-1:0]         i_prog_wr_data,
    output logic [LEN-1:0]         o_PC,
    output logic [LEN-1:0]         o_instruction,
    output logic [LEN-1:0]         o_PC_current,
    output logic                   o_halt
);

    import seg_instruction_fetch_pkg::*;

    localparam logic [LEN-1:0] PC_STEP = LEN'(PC_INCR);
    localparam logic [LEN-1:0] PC_INIT = LEN'(PC_RESET);
    localparam logic [LEN-1:0] NOP     = LEN'(NOP_WORD);

    logic [LEN-1:0] pc_q, pc_d;
    logic [LEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [LEN-1:0] ifid_instr_q, ifid_instr_d;
    logic           halt_q, halt_d;
    logic [LEN-1:0] fetch_word;
    logic [LEN-1:0] pc_plus4;
    logic [LEN-1:0] pc_next;

    mem_instruction #(
        .LEN        (LEN),
        .NB_MEM_ADDR(NB_MEM_ADDR)
    ) u_mem (
        .i_clk    (i_clk),
        .i_wr_en  (i_prog_wr_en),
        .i_wr_addr(i_prog_wr_addr),
        .i_wr_data(i_prog_wr_data),
        .i_rd_addr(pc_q[NB_MEM_ADDR+1:2]),
        .o_rd_data(fetch_word)
    );

    assign pc_plus4 = pc_q + PC_STEP;
    assign pc_next  = i_branch_flag ? i_PC_branch :
                      i_jump_flag   ? i_PC_dir_jump : pc_plus4;

    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        halt_d       = halt_q;
        if (i_enable) begin
            // A flush squashes a halt fetched down a wrong path, so it also unfreezes the PC.
            if ((~halt_q | i_flush) & (~i_stall | i_branch_flag)) begin
                pc_d = pc_next;
            end
            if (i_flush) begin
                ifid_pc_d    = '0;
                ifid_instr_d = NOP;
                halt_d       = 1'b0;
            end else if (~i_stall & ~halt_q) begin
                ifid_pc_d    = pc_plus4;
                ifid_instr_d = fetch_word;
                halt_d       = (fetch_word == HALT_WORD);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_q         <= PC_INIT;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
            halt_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            halt_q       <= halt_d;
        end
    end

    assign o_PC          = ifid_pc_q;
    assign o_instruction = ifid_instr_q;
    assign o_PC_current  = pc_q;
    assign o_halt        = halt_q;

endmodule

// File: tb/tb_seg_instruction_fetch.sv
// Bench for seg_instruction_fetch: directed program/stall/redirect/reset steps, then random traffic.
module tb_seg_instruction_fetch;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, en, stall, flush, jump, branch, wr_en;
    logic [31:0] jt, pcb, wdata;
    logic [9:0]  waddr;
    logic [31:0] o_PC, o_instruction, o_PC_current;
    logic        o_halt;

    int checks   = 0;
    int failures = 0;

    // Reference state: the program memory as the debug unit loaded it, plus the visible stage state.
    logic [31:0] mem_m [DEPTH];
    logic [31:0] pc_m, opc_m, ins_m;
    logic        halt_m;

    always #5 clk = ~clk;

    seg_instruction_fetch dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (en),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_jump_flag   (jump),
        .i_PC_dir_jump (jt),
        .i_branch_flag (branch),
        .i_PC_branch   (pcb),
        .i_prog_wr_en  (wr_en),
        .i_prog_wr_addr(waddr),
        .i_prog_wr_data(wdata),
        .o_PC          (o_PC),
        .o_instruction (o_instruction),
        .o_PC_current  (o_PC_current),
        .o_halt        (o_halt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".o_PC"}, o_PC, opc_m);
        chk({tag, ".o_instruction"}, o_instruction, ins_m);
        chk({tag, ".o_PC_current"}, o_PC_current, pc_m);
        chk({tag, ".o_halt"}, {31'd0, o_halt}, {31'd0, halt_m});
    endtask

    task automatic model_reset();
        pc_m = 0; opc_m = 0; ins_m = 0; halt_m = 1'b0;
    endtask

    task automatic quiet();
        stall = 0; flush = 0; jump = 0; branch = 0; wr_en = 0;
    endtask

    // One clock: predict from the spec's rules, advance, then compare.
    task automatic cyc(input string tag);
        logic [31:0] word, target, npc, nopc, nins;
        logic        nh;
        word   = mem_m[(pc_m >> 2) % DEPTH];
        target = branch ? pcb : (jump ? jt : pc_m + 32'd4);
        npc = pc_m; nopc = opc_m; nins = ins_m; nh = halt_m;
        if (en) begin
            if (flush) begin
                nins = 0; nopc = 0; nh = 1'b0;
            end else if (!stall && !halt_m) begin
                nins = word; nopc = pc_m + 32'd4; nh = (word == HALT);
            end
            if ((!halt_m || flush) && (!stall || branch)) npc = target;
        end
        if (!rst) begin
            npc = 0; nopc = 0; nins = 0; nh = 1'b0;
        end
        @(posedge clk);
        if (wr_en) mem_m[waddr] = wdata;
        pc_m = npc; opc_m = nopc; ins_m = nins; halt_m = nh;
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #3 rst = 1'b0;
        #1 model_reset();
        check_all(tag);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 0; en = 0; jt = 0; pcb = 0; waddr = 0; wdata = 0;
        quiet();
        model_reset();

        // Preload the whole RAM while held in reset; writes ignore reset and enable.
        wr_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            waddr = 10'(i);
            case (i)
                0:       wdata = 32'h0109_4020;
                1:       wdata = 32'h8C22_0004;
                2:       wdata = 32'hAC22_0008;
                3:       wdata = HALT;
                default: wdata = $urandom() & 32'h7FFF_FFFF;
            endcase
            cyc("preload");
        end
        wr_en = 0;
        chk("reset.PC", o_PC_current, 32'h0);
        chk("reset.instr", o_instruction, 32'h0);

        // Straight-line program ending in HALT.
        rst = 1;
        cyc("idle_disabled");
        en = 1;
        cyc("prog0"); chk("prog0.instr", o_instruction, 32'h0109_4020); chk("prog0.pc", o_PC, 32'h4);
        cyc("prog1"); chk("prog1.instr", o_instruction, 32'h8C22_0004); chk("prog1.pc", o_PC, 32'h8);
        cyc("prog2"); chk("prog2.instr", o_instruction, 32'hAC22_0008); chk("prog2.pc", o_PC, 32'hC);
        cyc("prog3"); chk("prog3.instr", o_instruction, HALT); chk("prog3.halt", {31'd0, o_halt}, 32'd1);
        cyc("halted0");
        cyc("halted1"); chk("halted.pcfreeze", o_PC_current, 32'h10);

        // Flush squashes the halt and takes the jump.
        flush = 1; jump = 1; jt = 32'h40;
        cyc("haltflush"); chk("haltflush.halt", {31'd0, o_halt}, 32'd0);
        chk("haltflush.pc", o_PC_current, 32'h40);
        quiet();
        cyc("after_haltflush"); chk("after_haltflush.pc", o_PC, 32'h44);

        // Asynchronous reset between edges, then redirect from PC=4.
        async_reset("async_rst0");
        chk("async_rst0.instr", o_instruction, 32'h0);
        cyc("restart0"); chk("restart0.instr", o_instruction, 32'h0109_4020);
        flush = 1; jump = 1; jt = 32'h40;
        cyc("jumpflush"); chk("jumpflush.instr", o_instruction, 32'h0);
        quiet();
        cyc("jumptarget"); chk("jumptarget.pc", o_PC, 32'h44);

        // Two-cycle stall at PC=8.
        async_reset("async_rst1");
        cyc("s0"); cyc("s1"); chk("s1.pcur", o_PC_current, 32'h8);
        stall = 1;
        cyc("stall0"); cyc("stall1"); chk("stall1.pcur", o_PC_current, 32'h8);
        stall = 0;
        cyc("unstall"); chk("unstall.instr", o_instruction, 32'hAC22_0008);

        // Branch and jump together under stall: branch wins and overrides stall.
        stall = 1; branch = 1; pcb = 32'h20; jump = 1; jt = 32'h40;
        cyc("brjmp"); chk("brjmp.pcur", o_PC_current, 32'h20);
        quiet();

        // Jump under stall is ignored.
        stall = 1; jump = 1; jt = 32'h80;
        cyc("jmpstall"); chk("jmpstall.pcur", o_PC_current, 32'h20);
        quiet();

        // Random traffic, including HALT words, wrapping targets and disabled cycles.
        for (int i = 0; i < 600; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            stall  = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 5) == 0);
            jump   = ($urandom_range(0, 6) == 0);
            branch = ($urandom_range(0, 7) == 0);
            jt     = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 63) * 4);
            pcb    = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 63) * 4);
            wr_en  = ($urandom_range(0, 3) == 0);
            waddr  = 10'($urandom_range(0, 63));
            wdata  = ($urandom_range(0, 7) == 0) ? HALT : $urandom();
            cyc("rand");
        end
        quiet();
        en = 1;

        // Memory survives reset.
        async_reset("async_rst2");
        cyc("final_fetch"); chk("final_fetch.pc", o_PC, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_instruction_fetch.md
Name: seg_instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline, directly upstream of seg_instruction_decode. It holds the PC and an instruction memory that the debug unit loads. It selects the next PC from branch, jump or sequential sources. Its IF/ID pipeline register supplies i_PC and i_instruction to decode, with stall, flush and halt handling.

Parameters:
LEN, 32, datapath/PC/instruction width
NB_MEM_ADDR, 10, instruction-memory word-address bits (depth 2**NB_MEM_ADDR words)
HALT_WORD, 32'hFFFFFFFF, encoding that stops fetch

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_enable  in  1  global run/step enable from debug unit; 0 freezes all state
i_stall  in  1  hazard-unit stall: hold PC and IF/ID
i_flush  in  1  squash IF/ID contents (write NOP)
i_jump_flag  in  1  decode resolved J/JAL/JR/JALR
i_PC_dir_jump  in  LEN  jump target from decode
i_branch_flag  in  1  taken branch (PCSrc)
i_PC_branch  in  LEN  branch target
i_prog_wr_en  in  1  instruction-memory write strobe
i_prog_wr_addr  in  NB_MEM_ADDR  word address to write
i_prog_wr_data  in  LEN  instruction word to write
o_PC  out  LEN  IF/ID: PC+4 of latched instruction
o_instruction  out  LEN  IF/ID: latched instruction
o_PC_current  out  LEN  current fetch PC (debug)
o_halt  out  1  fetch halted (HALT_WORD in IF/ID)

Behaviour:
- Reset (i_rst=0, async): PC=0, o_PC=0, o_instruction=0 (NOP), o_halt=0. Memory contents are not reset.
- Memory read is asynchronous: fetch_word = mem[PC[NB_MEM_ADDR+1:2]]. PC[1:0] is ignored. The address wraps modulo depth.
- Memory write is synchronous: if i_prog_wr_en then mem[i_prog_wr_addr] <= i_prog_wr_data, regardless of i_enable. A fetch from the same address in the same cycle sees the old word.
- Next PC priority: i_branch_flag -> i_PC_branch; else i_jump_flag -> i_PC_dir_jump; else PC+4. Arithmetic is mod 2**LEN.
- PC update at posedge when i_enable & ~o_halt & (~i_stall | i_branch_flag). A taken branch overrides stall; a jump under stall is ignored.
- IF/ID update at posedge when i_enable:
  - i_flush=1: o_instruction<=0, o_PC<=0. Flush has priority over stall.
  - else if ~i_stall & ~o_halt: o_instruction<=fetch_word, o_PC<=PC+4.
  - else: hold.
- Halt:
  - o_halt<=1 when HALT_WORD is latched into IF/ID by a non-flushed update.
  - Once set, PC freezes and IF/ID holds, so HALT stays visible to decode.
  - If i_flush=1 while o_halt=1, the halt is squashed (wrong path): o_halt<=0, IF/ID<=NOP, and the PC follows the normal next-PC rule in that cycle.
  - Otherwise o_halt clears only on reset.
- i_enable=0: no PC, IF/ID or halt change. Memory writes still occur.
- Latency: instruction at PC appears on o_instruction 1 cycle after PC is presented. A redirect costs one bubble; the hazard unit asserts i_flush.
- Reset asserted mid-run takes effect immediately (async). Deassertion is sampled at the next posedge, where the first fetch is from address 0.

Decomposition:
- Shared package/header: LEN, NOP_WORD (32'h0), HALT_WORD, PC_RESET (0), PC_INCR (4). Reused by decode and the debug unit.
- One sub-module, mem_instruction: async-read, sync-write RAM, parameters LEN and NB_MEM_ADDR.
- The PC register, next-PC mux and IF/ID register stay in seg_instruction_fetch.

Test Plan:
- Load mem[0..3]={32'h01094020, 32'h8C220004, 32'hAC220008, HALT_WORD} with i_enable=0, release reset, i_enable=1 -> o_instruction 01094020/8C220004/AC220008/FFFFFFFF on consecutive cycles; o_PC 4/8/C/10; o_halt=1 from the fourth cycle; PC frozen at 0x10.
- At PC=0x8 assert i_stall for 2 cycles -> PC and IF/ID hold 2 cycles, then resume with the mem[2] word.
- i_jump_flag=1, i_PC_dir_jump=0x40, i_flush=1 for one cycle at PC=0x4 -> next o_instruction=0, o_PC=0; following cycle fetches mem[16] with o_PC=0x44.
- i_branch_flag=1 (i_PC_branch=0x20) and i_jump_flag=1 (0x40) together with i_stall=1 -> PC becomes 0x20 (branch wins, overrides stall).
- Halt latched, then i_flush=1 -> o_halt returns to 0, o_instruction=0, fetch resumes at the redirect/next PC.
- Drive i_rst=0 mid-run between clock edges -> all outputs are 0 immediately; after release the first fetch is from address 0 and memory contents are retained.
